// File: rtl/up2_pkg.sv
// Shared constants for the UP2 timer push-button front end: clock rate,
// default debounce/repeat timings and the repeat FSM state encoding.
package up2_pkg;

    localparam int unsigned MCLK_HZ               = 25175000;
    localparam int unsigned DEBOUNCE_CYCLES_DFLT  = 251750;
    localparam int unsigned REPEAT_DELAY_DFLT     = 12587500;
    localparam int unsigned REPEAT_PERIOD_DFLT    = 2517500;
    localparam int unsigned CNT_W_DFLT            = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_HOLD   = 2'd3
    } rep_state_e;

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser plus stability counter for an active-low button;
// produces the debounced level and single-edge rise/fall strobes.
module debounce_filter #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 8
) (
    input  logic clk,
    input  logic srst,
    input  logic bt_n_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic             toggle;

    // rise/fall are combinational so the FSM can react on the same edge LEVEL toggles
    assign toggle  = (s2_q != level_q) && (dcnt_q == DEB_LAST);
    assign rise_o  = toggle & ~level_q;
    assign fall_o  = toggle &  level_q;
    assign level_o = level_q;

    always_comb begin
        dcnt_d  = '0;
        level_d = level_q;
        if (s2_q != level_q) begin
            if (dcnt_q == DEB_LAST) begin
                level_d = ~level_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            dcnt_q  <= '0;
        end else begin
            s1_q    <= ~bt_n_i;
            s2_q    <= s1_q;
            level_q <= level_d;
            dcnt_q  <= dcnt_d;
        end
    end

endmodule

// File: rtl/button_repeat.sv
// Push-button conditioner: debounced level, one-cycle PRESS per press and
// optional auto-repeat (initial delay, then fixed period) while held.
module button_repeat
    import up2_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DFLT,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DFLT,
    parameter int unsigned CNT_W           = CNT_W_DFLT
) (
    input  logic MCLK,
    input  logic RST,
    input  logic BT_N,
    input  logic REPEAT_EN,
    output logic LEVEL,
    output logic PRESS,
    output logic HELD
);

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    rep_state_e       state_q, state_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             press_q, press_d;
    logic             held_q;
    logic             rise, fall;

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk     (MCLK),
        .srst    (RST),
        .bt_n_i  (BT_N),
        .level_o (LEVEL),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    // Release has priority over a coinciding terminal count, then REPEAT_EN
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        press_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    rcnt_d  = '0;
                    state_d = REPEAT_EN ? ST_DELAY : ST_HOLD;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                if (fall) begin
                    rcnt_d  = '0;
                    state_d = ST_IDLE;
                end else if (!REPEAT_EN) begin
                    rcnt_d  = '0;
                    state_d = ST_HOLD;
                end else if (rcnt_q == ((state_q == ST_DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
                    press_d = 1'b1;
                    rcnt_d  = '0;
                    state_d = ST_REPEAT;
                end else begin
                    rcnt_d  = rcnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (fall) begin
                    rcnt_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                rcnt_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            rcnt_q  <= '0;
            press_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            press_q <= press_d;
            held_q  <= (state_d == ST_REPEAT);
        end
    end

    assign PRESS = press_q;
    assign HELD  = held_q;

endmodule

// File: tb/tb_button_repeat.sv
// Directed bench for button_repeat with short timings (debounce 4,
// delay 10, period 3); per-edge output logs compared to hand-built patterns.
module tb_button_repeat;
    import up2_pkg::*;

    logic MCLK = 1'b0;
    logic RST  = 1'b1;
    logic BT_N = 1'b1;
    logic REPEAT_EN = 1'b1;
    logic LEVEL, PRESS, HELD;

    int errors = 0;
    int checks = 0;
    int ed = 0;
    logic [63:0] press_log, held_log, level_log;

    button_repeat #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3),
        .CNT_W           (8)
    ) dut (
        .MCLK      (MCLK),
        .RST       (RST),
        .BT_N      (BT_N),
        .REPEAT_EN (REPEAT_EN),
        .LEVEL     (LEVEL),
        .PRESS     (PRESS),
        .HELD      (HELD)
    );

    always #5 MCLK = ~MCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("check %s ok (%h)", tag, obs);
        end
    endtask

    function automatic logic [63:0] bit_at(input int n);
        logic [63:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] span(input int lo, input int hi);
        logic [63:0] v;
        v = '0;
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Outputs are sampled 1 time unit after the edge; log index = edge number
    task automatic step();
        @(posedge MCLK);
        #1;
        if (ed < 64) begin
            press_log[ed] = PRESS;
            held_log[ed]  = HELD;
            level_log[ed] = LEVEL;
        end
        ed++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input string tag);
        RST = 1'b1;
        BT_N = 1'b1;
        REPEAT_EN = 1'b1;
        steps(2);
        check({tag, "_rst_out"}, {61'd0, LEVEL, PRESS, HELD}, 64'd0);
        check({tag, "_rst_state"}, 64'(dut.state_q), 64'(ST_IDLE));
        RST = 1'b0;
        steps(3);
        press_log = '0;
        held_log  = '0;
        level_log = '0;
        ed = 0;
    endtask

    initial begin
        press_log = '0;
        held_log  = '0;
        level_log = '0;

        // Clean press held, then released at edge 24 (fall at 29)
        do_reset("s1");
        BT_N = 1'b0;
        steps(24);
        BT_N = 1'b1;
        steps(10);
        check("s1_press", press_log,
              bit_at(5) | bit_at(15) | bit_at(18) | bit_at(21) | bit_at(24) | bit_at(27));
        check("s1_held", held_log, span(15, 28));
        check("s1_level", level_log, span(5, 28));
        check("s1_state", 64'(dut.state_q), 64'(ST_IDLE));

        // Bounce: 3 low, 2 high, 3 low, then released
        do_reset("s2");
        BT_N = 1'b0; steps(3);
        BT_N = 1'b1; steps(2);
        BT_N = 1'b0; steps(3);
        BT_N = 1'b1; steps(12);
        check("s2_press", press_log, 64'd0);
        check("s2_level", level_log, 64'd0);

        // REPEAT_EN=0: single press, HOLD, release quietly
        do_reset("s3");
        REPEAT_EN = 1'b0;
        BT_N = 1'b0;
        steps(40);
        check("s3_state_hold", 64'(dut.state_q), 64'(ST_HOLD));
        BT_N = 1'b1;
        steps(10);
        check("s3_press", press_log, bit_at(5));
        check("s3_held", held_log, 64'd0);
        check("s3_level", level_log, span(5, 44));
        check("s3_state_idle", 64'(dut.state_q), 64'(ST_IDLE));

        // Fall lands on the edge-18 repeat terminal
        do_reset("s4");
        BT_N = 1'b0;
        steps(13);
        BT_N = 1'b1;
        steps(13);
        check("s4_press18", 64'(press_log[18]), 64'd0);
        check("s4_press", press_log, bit_at(5) | bit_at(15));
        check("s4_level", level_log, span(5, 17));
        check("s4_held", held_log, span(15, 17));
        check("s4_state", 64'(dut.state_q), 64'(ST_IDLE));

        // One-cycle RST at edge 12 while held
        do_reset("s5");
        BT_N = 1'b0;
        steps(12);
        RST = 1'b1;
        step();
        RST = 1'b0;
        steps(23);
        check("s5_press", press_log,
              bit_at(5) | bit_at(18) | bit_at(28) | bit_at(31) | bit_at(34));
        check("s5_level", level_log, span(5, 11) | span(18, 35));
        check("s5_held", held_log, span(28, 35));

        // REPEAT_EN dropped at edge 16, raised at 25, release, re-press at 40
        do_reset("s6");
        BT_N = 1'b0;
        steps(16);
        REPEAT_EN = 1'b0;
        steps(9);
        REPEAT_EN = 1'b1;
        steps(5);
        check("s6_state_hold", 64'(dut.state_q), 64'(ST_HOLD));
        BT_N = 1'b1;
        steps(10);
        BT_N = 1'b0;
        steps(8);
        check("s6_press", press_log, bit_at(5) | bit_at(15) | bit_at(45));
        check("s6_held", held_log, bit_at(15));
        check("s6_level", level_log, span(5, 34) | span(45, 47));
        check("s6_state_delay", 64'(dut.state_q), 64'(ST_DELAY));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_repeat.md
Name: button_repeat

Overview:
- Upstream conditioner for each timer push-button (START_STOP, RESET, ADD_SEC, ADD_MIN).
- Turns a raw active-low UP2 button into clean single-cycle PRESS pulses on the MCLK domain.
- Optionally auto-repeats while the button is held, so ADD_SEC/ADD_MIN step continuously and the counters see one increment per pulse.

Parameters:
DEBOUNCE_CYCLES, 251750, consecutive stable cycles needed to accept a level change (~10 ms at 25.175 MHz); must be >=1
REPEAT_DELAY, 12587500, cycles from the initial PRESS to the first repeat PRESS (~0.5 s); must be >=1
REPEAT_PERIOD, 2517500, cycles between subsequent repeat PRESS pulses (~0.1 s); must be >=1
CNT_W, 24, width of both internal counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)-1

Ports:
MCLK  input  1  system clock; the block has one clock
RST  input  1  synchronous, active-high reset
BT_N  input  1  raw button, asynchronous, 0 while pressed
REPEAT_EN  input  1  1 = auto-repeat allowed; sampled every cycle
LEVEL  output  1  debounced button state, 1 = pressed
PRESS  output  1  one-cycle pulse per accepted press and per repeat
HELD  output  1  1 while in the REPEAT state

Behaviour:
- One clock (MCLK). Reset is synchronous and active-high (RST). All outputs are registered.
- Reset values: sync flops 0 (not pressed), LEVEL=0, PRESS=0, HELD=0, both counters 0, FSM=IDLE.
- Synchroniser:
  - Two flops: s1 <= ~BT_N, s2 <= s1.
  - Only s2 is used downstream.
- Debounce filter:
  - When s2 != LEVEL: dcnt increments each cycle.
  - When s2 == LEVEL: dcnt clears to 0.
  - When s2 != LEVEL and dcnt == DEBOUNCE_CYCLES-1: LEVEL toggles and dcnt <= 0.
  - "rise" / "fall" = the edge on which LEVEL toggles 0->1 / 1->0.
- Latency:
  - Count the first edge sampling BT_N low as edge 0.
  - LEVEL and PRESS go high after edge DEBOUNCE_CYCLES+1.
  - Release timing is symmetric.
- FSM states: IDLE, DELAY, REPEAT, HOLD. rcnt is the repeat counter.
  - IDLE: on rise, PRESS<=1 and rcnt<=0. Go to DELAY if REPEAT_EN=1, otherwise HOLD.
  - DELAY: rcnt increments. At rcnt==REPEAT_DELAY-1: PRESS<=1, rcnt<=0, go to REPEAT.
  - REPEAT: rcnt increments. At rcnt==REPEAT_PERIOD-1: PRESS<=1, rcnt<=0. HELD=1 while in this state.
  - HOLD: no pulses; wait for release.
  - In DELAY/REPEAT, REPEAT_EN=0 -> go to HOLD, no pulse that edge, rcnt<=0.
  - In HOLD, REPEAT_EN returning to 1 does not restart repeating until the next press.
  - From any state, fall -> IDLE with rcnt<=0.
- PRESS is high for exactly one cycle per event and is never asserted on release.
- Simultaneous events: if fall coincides with a rcnt terminal count, release wins and no PRESS is issued.
- Glitches: any bounce shorter than DEBOUNCE_CYCLES cycles (after synchronisation) produces no LEVEL change and no PRESS.
- Reset mid-operation: everything is cleared at once and any pending pulse is dropped. If the button is still held after reset deasserts, the press is re-qualified from scratch: new debounce, then a new PRESS.
- Wrap-around: counters never exceed their terminal values, so overflow is impossible when CNT_W is sized per its rule.

Decomposition:
- Shared package (up2_pkg):
  - MCLK_HZ = 25175000.
  - Default debounce/repeat cycle constants.
  - FSM state encoding constants (2 bits: IDLE=0, DELAY=1, REPEAT=2, HOLD=3).
- One sub-module: debounce_filter (synchroniser + dcnt + LEVEL register; outputs LEVEL and rise/fall strobes).
- The repeat FSM lives in button_repeat.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_EN=1 unless stated):
- Clean press at edge 0, held -> LEVEL=1 and PRESS pulse after edge 5; repeat PRESS after edges 15, 18, 21; HELD=1 from edge 15.
- Bounce: BT_N low 3 cycles, high 2, low 3, then high -> LEVEL stays 0; PRESS never asserted.
- REPEAT_EN=0 press held for 40 cycles -> exactly one PRESS (after edge 5); HELD stays 0; FSM in HOLD; release returns to IDLE with no pulse.
- Release timed so that the fall coincides with the edge-18 repeat terminal -> no PRESS at edge 18; FSM IDLE; LEVEL=0.
- RST pulse for 1 cycle at edge 12 while held -> all outputs 0 after edge 12; button still held -> new PRESS 6 edges after RST deasserts, then the repeat sequence restarts.
- Drop REPEAT_EN to 0 at edge 16 (in REPEAT) -> no further PRESS; HELD=0; raising REPEAT_EN at edge 25 gives no pulses until release and a re-press.
